cs_resolver: RTL



---
 rtl/mul_pkg.sv | 18 +
 rtl/cs_chunk_adder.sv | 14 +
 rtl/cs_resolver.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the multiplier back end.
package mul_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-chunk build still needs a 1-bit counter so the select logic stays uniform.
    function automatic int cnt_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/cs_chunk_adder.sv
// Combinational CHUNK-bit adder with carry in/out; one slice of the ripple resolver.
module cs_chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/cs_resolver.sv
// Resolves a carry-save pair (C, S) into C+S, CHUNK bits per cycle, with valid/ready on both sides.
module cs_resolver
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = cnt_width(NCHUNK);

    if (CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("cs_resolver: WIDTH must be a positive multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d, s_q, s_d, sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, valid_q, valid_d;

    int unsigned      base;
    logic [CHUNK-1:0] add_a, add_b, add_sum;
    logic             add_cout;
    logic             accept, last_chunk;

    // A single adder slice is shared across cycles; cnt steers which chunk it sees.
    always_comb begin
        base  = int'(cnt_q) * CHUNK;
        add_a = c_q[base +: CHUNK];
        add_b = s_q[base +: CHUNK];
    end

    cs_chunk_adder #(.CHUNK(CHUNK)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign in_ready   = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through this block infers a latch.
        state_d = state_q;
        c_d     = c_q;
        s_d     = s_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        valid_d = valid_q;

        if (accept) begin
            c_d     = in_c;
            s_d     = in_s;
            carry_d = 1'b0;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = ADD;
        end else begin
            case (state_q)
                ADD: begin
                    sum_d[base +: CHUNK] = add_sum;
                    carry_d              = add_cout;
                    if (last_chunk) begin
                        cout_d  = add_cout;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    // Consume without a new pair: drop valid but keep the last sum visible.
                    if (out_ready) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: operand registers are reset too, so nothing downstream can ever observe X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            s_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            c_q     <= c_d;
            s_q     <= s_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule
